// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in/parallel-out deserializer.
// Build option: SIPO_PARITY_CHECK_EN adds a trailing even-parity bit per word
// (S_PAR state plus a parity_err output).
package sipo_pkg;

  // Receive FSM states; S_PAR exists only when a parity bit trails the data.
  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT
`ifdef SIPO_PARITY_CHECK_EN
    , S_PAR
`endif
  } state_t;

  // Width of a counter that must hold the values 0..width inclusive.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_out_buf.sv
// One-word output holding register with valid/ready handshake and a sticky
// overrun flag. A word completing while the buffer is full and not being
// consumed is dropped.
// Build option: SIPO_PARITY_CHECK_EN carries a parity_err bit alongside the word.
module sipo_out_buf #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
`ifdef SIPO_PARITY_CHECK_EN
  input  logic             load_perr,
  output logic             parity_err,
`endif
  input  logic             par_ready,
  input  logic             overrun_clr,
  output logic [WIDTH-1:0] par_out,
  output logic             par_valid,
  output logic             overrun
);

  logic can_load;

  // The buffer can take a new word when it is empty or being drained this cycle.
  assign can_load = !par_valid || par_ready;

  // Holding register and valid flag; a load in the handshake cycle keeps valid high.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_out   <= '0;
      par_valid <= 1'b0;
`ifdef SIPO_PARITY_CHECK_EN
      parity_err <= 1'b0;
`endif
    end else if (load && can_load) begin
      par_out   <= load_data;
      par_valid <= 1'b1;
`ifdef SIPO_PARITY_CHECK_EN
      parity_err <= load_perr;
`endif
    end else if (par_valid && par_ready) begin
      par_valid <= 1'b0;
    end
  end

  // Sticky overrun: set on a dropped word, cleared on request; set wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (load && !can_load) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer: shifts in WIDTH bits qualified by
// ser_valid, then hands the word to a one-word valid/ready output buffer.
// Build option: SIPO_PARITY_CHECK_EN expects one trailing even-parity bit per
// word and reports parity_err with the delivered word.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ser_in,
  input  logic                       ser_valid,
  output logic [WIDTH-1:0]           par_out,
  output logic                       par_valid,
  input  logic                       par_ready,
  output logic                       overrun,
  input  logic                       overrun_clr,
  output logic [cnt_w(WIDTH)-1:0]    bit_cnt
`ifdef SIPO_PARITY_CHECK_EN
  , output logic                     parity_err
`endif
);

  localparam int CNT_W = cnt_w(WIDTH);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sr_q, sr_d, shifted;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               word_done;
  logic [WIDTH-1:0]   word_data;
`ifdef SIPO_PARITY_CHECK_EN
  logic               word_perr;
`endif

  // Shift register contents after taking in ser_in, in the configured bit order.
  always_comb begin
    if (MSB_FIRST) shifted = {sr_q[WIDTH-2:0], ser_in};
    else           shifted = {ser_in, sr_q[WIDTH-1:1]};
  end

  // Next-state, shift and completion decode; the completed word includes the
  // bit sampled in this same cycle.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    word_done = 1'b0;
    word_data = shifted;
`ifdef SIPO_PARITY_CHECK_EN
    word_perr = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (ser_valid) begin
          sr_d    = shifted;
          cnt_d   = CNT_W'(1);
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (ser_valid) begin
          sr_d = shifted;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef SIPO_PARITY_CHECK_EN
            cnt_d   = CNT_W'(WIDTH);
            state_d = S_PAR;
`else
            cnt_d     = '0;
            word_done = 1'b1;
            state_d   = S_IDLE;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
`ifdef SIPO_PARITY_CHECK_EN
      S_PAR: begin
        if (ser_valid) begin
          word_data = sr_q;
          word_perr = ^{sr_q, ser_in};
          word_done = 1'b1;
          cnt_d     = '0;
          state_d   = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // FSM, shift register and bit counter; reset discards any partial word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bit_cnt = cnt_q;

  sipo_out_buf #(
    .WIDTH(WIDTH)
  ) u_out_buf (
    .clk         (clk),
    .rst         (rst),
    .load        (word_done),
    .load_data   (word_data),
`ifdef SIPO_PARITY_CHECK_EN
    .load_perr   (word_perr),
    .parity_err  (parity_err),
`endif
    .par_ready   (par_ready),
    .overrun_clr (overrun_clr),
    .par_out     (par_out),
    .par_valid   (par_valid),
    .overrun     (overrun)
  );

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer (WIDTH=4): one MSB-first and one
// LSB-first instance share the same serial stimulus.
// Build option: SIPO_PARITY_CHECK_EN adds a parity bit per word and parity checks.
module tb_sipo_deserializer;

  logic       clk = 1'b0;
  logic       rst, ser_in, ser_valid, par_ready, overrun_clr;
  logic [3:0] po_m, po_l;
  logic       pv_m, pv_l, ov_m, ov_l;
  logic [2:0] bc_m, bc_l;
`ifdef SIPO_PARITY_CHECK_EN
  logic       pe_m, pe_l;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .ser_in(ser_in), .ser_valid(ser_valid),
    .par_out(po_m), .par_valid(pv_m), .par_ready(par_ready),
    .overrun(ov_m), .overrun_clr(overrun_clr), .bit_cnt(bc_m)
`ifdef SIPO_PARITY_CHECK_EN
    , .parity_err(pe_m)
`endif
  );

  sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .ser_in(ser_in), .ser_valid(ser_valid),
    .par_out(po_l), .par_valid(pv_l), .par_ready(par_ready),
    .overrun(ov_l), .overrun_clr(overrun_clr), .bit_cnt(bc_l)
`ifdef SIPO_PARITY_CHECK_EN
    , .parity_err(pe_l)
`endif
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Advance one clock; outputs are then observed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ser_valid = 1'b1;
    ser_in    = b;
    tick();
    ser_valid = 1'b0;
    ser_in    = 1'b0;
  endtask

  // Sends d[3] first; par_ready/overrun_clr are applied on the completing cycle.
  task automatic send_word(input logic [3:0] d, input logic par,
                           input logic ready_last, input logic clr_last);
    for (int i = 3; i >= 0; i--) begin
`ifndef SIPO_PARITY_CHECK_EN
      if (i == 0) begin
        par_ready   = ready_last;
        overrun_clr = clr_last;
      end
`endif
      send_bit(d[i]);
    end
`ifdef SIPO_PARITY_CHECK_EN
    par_ready   = ready_last;
    overrun_clr = clr_last;
    send_bit(par);
`else
    if (par) begin end
`endif
    overrun_clr = 1'b0;
  endtask

  initial begin
    logic [3:0] bits;
    rst = 1'b1; ser_in = 1'b0; ser_valid = 1'b0; par_ready = 1'b0; overrun_clr = 1'b0;
    tick(); tick();
    check("rst_par_out", po_m, 0);
    check("rst_par_valid", pv_m, 0);
    check("rst_overrun", ov_m, 0);
    check("rst_bit_cnt", bc_m, 0);
    rst = 1'b0;
    tick();

    // Consecutive bits 1,0,1,1 with consumer always ready.
    par_ready = 1'b1;
    send_word(4'hB, 1'b1, 1'b1, 1'b0);
    check("t1_valid", pv_m, 1);
    check("t1_msb_word", po_m, 4'hB);
    check("t1_lsb_word", po_l, 4'hD);
    tick();
    check("t1_valid_one_cycle", pv_m, 0);

    // Same bits with two idle cycles between each; bit_cnt must hold in gaps.
    bits = 4'hB;
    for (int k = 1; k <= 4; k++) begin
      send_bit(bits[4-k]);
`ifdef SIPO_PARITY_CHECK_EN
      check("t2_bit_cnt", bc_l, k);
`else
      check("t2_bit_cnt", bc_l, (k == 4) ? 0 : k);
`endif
      tick(); tick();
`ifdef SIPO_PARITY_CHECK_EN
      check("t2_bit_cnt_hold", bc_l, k);
`else
      check("t2_bit_cnt_hold", bc_l, (k == 4) ? 0 : k);
`endif
    end
`ifdef SIPO_PARITY_CHECK_EN
    send_bit(1'b1);
    check("t2_bit_cnt_wrap", bc_l, 0);
`endif
    check("t2_lsb_word", po_l, 4'hD);
    check("t2_msb_word", po_m, 4'hB);

    // Consumer stalled: second word is dropped and overrun sticks.
    par_ready = 1'b0;
    send_word(4'hB, 1'b1, 1'b0, 1'b0);
    check("t3_valid", pv_m, 1);
    check("t3_word", po_m, 4'hB);
    check("t3_no_overrun", ov_m, 0);
    send_word(4'h6, 1'b0, 1'b0, 1'b0);
    check("t3_word_kept", po_m, 4'hB);
    check("t3_overrun", ov_m, 1);
    check("t3_still_valid", pv_m, 1);
    tick();
    check("t3_overrun_sticky", ov_m, 1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("t3_overrun_clr", ov_m, 0);
    check("t3_clr_keeps_data", po_m, 4'hB);
    // Clear coincident with a new drop: set wins.
    send_word(4'h6, 1'b0, 1'b0, 1'b1);
    check("t3_set_wins", ov_m, 1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("t3_clr_again", ov_m, 0);

    // Ready raised in the exact completion cycle: new word loads, no overrun.
    send_word(4'h6, 1'b0, 1'b1, 1'b0);
    check("t4_word", po_m, 4'h6);
    check("t4_valid", pv_m, 1);
    check("t4_no_overrun", ov_m, 0);
    tick();
    check("t4_drained", pv_m, 0);

    // Reset mid-word, then a clean word.
    send_bit(1'b1);
    send_bit(1'b1);
    check("t5_partial_cnt", bc_m, 2);
    rst = 1'b1;
    #2;
    check("t5_async_rst_cnt", bc_m, 0);
    check("t5_async_rst_word", po_m, 0);
    tick();
    rst = 1'b0;
    tick();
    send_word(4'hA, 1'b0, 1'b1, 1'b0);
    check("t5_msb_word", po_m, 4'hA);
    check("t5_lsb_word", po_l, 4'h5);
    check("t5_valid", pv_m, 1);

`ifdef SIPO_PARITY_CHECK_EN
    // Parity: 4'hB has three ones, so even parity bit is 1.
    send_word(4'hB, 1'b1, 1'b1, 1'b0);
    check("t6_parity_ok", pe_m, 0);
    check("t6_word", po_m, 4'hB);
    send_word(4'hB, 1'b0, 1'b1, 1'b0);
    check("t6_parity_err", pe_m, 1);
    check("t6_err_valid", pv_m, 1);
    check("t6_err_word", po_m, 4'hB);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
- Serial-in/parallel-out deserializer; receive-side counterpart of the team's 4-bit PISO shifter.
- Collects WIDTH serial bits qualified by ser_valid into a shift register, then presents the completed word on a valid/ready parallel interface.
- Includes a one-word output holding register and a sticky overrun flag.
- Sits between a serial link front-end and a parallel consumer (register file or FIFO).

Parameters:
- WIDTH, 4, parallel word width in bits (>=2).
- MSB_FIRST, 1, 1: first received bit lands in par_out[WIDTH-1]; 0: first received bit lands in par_out[0].

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-high.
- ser_in  input  1  serial data bit.
- ser_valid  input  1  ser_in sampled on a clk edge only when high.
- par_out  output  WIDTH  completed word.
- par_valid  output  1  par_out holds an unconsumed word.
- par_ready  input  1  consumer accepts the word when par_valid && par_ready.
- overrun  output  1  sticky; a completed word was dropped.
- overrun_clr  input  1  synchronous clear of overrun.
- bit_cnt  output  $clog2(WIDTH+1)  bits of the current word received so far.
- parity_err  output  1  present only with SIPO_PARITY_CHECK_EN.

Behaviour:
- Reset values: par_out=0, par_valid=0, overrun=0, bit_cnt=0, shift register=0, FSM=S_IDLE, parity_err=0.
- Reset mid-word discards all partial bits. No resumption.
- FSM states (sipo_pkg::state_t):
  - S_IDLE (bit_cnt==0) -> S_SHIFT on the first ser_valid.
  - S_SHIFT: bit_cnt increments on each ser_valid.
  - On the WIDTH-th data bit: go to S_PAR if parity is enabled; otherwise complete the word and return to S_IDLE.
  - S_PAR: the next ser_valid samples the parity bit, completes the word, and returns to S_IDLE.
- ser_valid low: hold all state. No timeout.
- Shift: MSB_FIRST=1 uses sr <= {sr[WIDTH-2:0], ser_in}; MSB_FIRST=0 uses sr <= {ser_in, sr[WIDTH-1:1]}.
- Completion: the assembled word, including the bit sampled in the same cycle, is loaded into par_out and par_valid rises on the following edge. Latency from the edge sampling the last bit to visible par_valid is 1 clk.
- Back-to-back words with no idle cycles are supported. bit_cnt wraps to 0 at completion.
- Handshake:
  - par_valid deasserts the cycle after par_valid && par_ready unless a new word completes that same cycle.
  - par_out stays stable while par_valid && !par_ready.
- Simultaneous completion and handshake: the new word loads, par_valid stays 1, no overrun.
- Completion while par_valid && !par_ready: the new word is dropped, par_out is unchanged, and overrun sets on the next edge.
- overrun_clr coincident with a new overrun event: set wins.
- overrun_clr has no effect on data.
- par_ready while par_valid=0 is ignored.

Optional Feature:
- Macro SIPO_PARITY_CHECK_EN.
- Defined:
  - Each word carries WIDTH data bits plus one trailing even-parity bit, handled by S_PAR.
  - parity_err = ^{data, parity_bit}. It is registered with par_out, has the same valid qualification, and is replaced on each load.
  - Erroneous words are still delivered.
- Undefined: no S_PAR state and no parity_err port. Words are exactly WIDTH bits.

Decomposition:
- Shared package sipo_pkg: state_t enum (S_IDLE, S_SHIFT, S_PAR) and the localparam CNT_W = $clog2(WIDTH+1) helper function.
- One natural sub-module: sipo_out_buf, the holding register plus valid/ready/overrun logic. The top keeps the FSM and shift register.

Test Plan (WIDTH=4 unless noted):
- MSB_FIRST=1, ser_in 1,0,1,1 on 4 consecutive ser_valid cycles, par_ready=1 -> par_out=4'hB, par_valid high 1 clk after 4th bit for exactly 1 cycle.
- MSB_FIRST=0, same bits with ser_valid gaps of 2 cycles -> par_out=4'hD; bit_cnt steps 1,2,3 then 0.
- par_ready=0, send 4'hB then 4'h6 -> par_out stays 4'hB, overrun=1. Pulse overrun_clr -> overrun=0.
- par_ready raised in the exact cycle the second word (4'h6) completes -> par_out=4'h6, par_valid continuous, overrun=0.
- rst asserted after 2 bits, then send 4'hA -> par_out=4'hA, no leftover bits.
- SIPO_PARITY_CHECK_EN, data 4'hB then parity 1 -> parity_err=0; data 4'hB then parity 0 -> parity_err=1, word still delivered.
